int_exe_cluster: RTL and testbench

//   Parametrised integer execution cluster: N_ALU single-cycle ALU lanes plus one pipelined

---
 rtl/int_exe_cluster.sv | 174 +++++++++++++++++
 tb/tb_int_exe_cluster.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_exe_cluster.sv
// Integer execution cluster: N_ALU single-cycle ALU lanes plus one MUL_LAT-deep multiplier lane.
// Latency: ALU result registered 1 cycle after issue; multiplier result exactly MUL_LAT cycles after issue.
// Backpressure: ALU lane ready when its output register is empty or draining; multiplier freezes whole pipe on stall.
module int_exe_cluster #(
  parameter int N_ALU   = 2,
  parameter int XLEN    = 32,
  parameter int ROB_W   = 6,
  parameter int MUL_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [N_ALU-1:0]       alu_valid_i,
  output logic [N_ALU-1:0]       alu_ready_o,
  input  logic [4*N_ALU-1:0]     alu_op_i,
  input  logic [XLEN*N_ALU-1:0]  alu_src1_i,
  input  logic [XLEN*N_ALU-1:0]  alu_src2_i,
  input  logic [ROB_W*N_ALU-1:0] alu_rob_i,
  output logic [N_ALU-1:0]       alu_cmt_valid_o,
  input  logic [N_ALU-1:0]       alu_cmt_ready_i,
  output logic [XLEN*N_ALU-1:0]  alu_cmt_data_o,
  output logic [ROB_W*N_ALU-1:0] alu_cmt_rob_o,
  input  logic                   mul_valid_i,
  output logic                   mul_ready_o,
  input  logic [1:0]             mul_op_i,
  input  logic [XLEN-1:0]        mul_src1_i,
  input  logic [XLEN-1:0]        mul_src2_i,
  input  logic [ROB_W-1:0]       mul_rob_i,
  output logic                   mul_cmt_valid_o,
  input  logic                   mul_cmt_ready_i,
  output logic [XLEN-1:0]        mul_cmt_data_o,
  output logic [ROB_W-1:0]       mul_cmt_rob_o
);

  localparam int SHW  = $clog2(XLEN);
  localparam int LAST = MUL_LAT - 1;

  // ALU datapath; undefined opcodes (11..15) produce zero
  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd6:    return {{(XLEN-1){1'b0}}, (a < b)};
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return $unsigned($signed(a) >>> sh);
      4'd10:   return b;
      default: return '0;
    endcase
  endfunction

  // ---------------------------------------------------------------- ALU lanes
  logic [N_ALU-1:0]            avld_q, avld_d;
  logic [N_ALU-1:0][XLEN-1:0]  adat_q, adat_d;
  logic [N_ALU-1:0][ROB_W-1:0] arob_q, arob_d;
  logic [N_ALU-1:0]            alu_fire;

  // Per-lane output register: load on issue, clear on commit, flush kills it
  always_comb begin
    avld_d      = avld_q;
    adat_d      = adat_q;
    arob_d      = arob_q;
    alu_ready_o = '0;
    alu_fire    = '0;
    for (int i = 0; i < N_ALU; i++) begin
      alu_ready_o[i] = !flush_i && (!avld_q[i] || alu_cmt_ready_i[i]);
      alu_fire[i]    = alu_valid_i[i] && alu_ready_o[i];
      if (flush_i) begin
        avld_d[i] = 1'b0;
      end else if (alu_fire[i]) begin
        // a same-cycle commit is implied by ready, so reloading keeps valid high
        avld_d[i] = 1'b1;
        adat_d[i] = alu_f(alu_op_i[i*4 +: 4], alu_src1_i[i*XLEN +: XLEN],
                          alu_src2_i[i*XLEN +: XLEN]);
        arob_d[i] = alu_rob_i[i*ROB_W +: ROB_W];
      end else if (alu_cmt_ready_i[i]) begin
        avld_d[i] = 1'b0;
      end
    end
  end

  // ALU lane state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      avld_q <= '0;
      adat_q <= '0;
      arob_q <= '0;
    end else begin
      avld_q <= avld_d;
      adat_q <= adat_d;
      arob_q <= arob_d;
    end
  end

  assign alu_cmt_valid_o = avld_q;
  assign alu_cmt_data_o  = adat_q;
  assign alu_cmt_rob_o   = arob_q;

  // ---------------------------------------------------------- multiplier lane
  logic [MUL_LAT-1:0]              mvld_q, mvld_d;
  logic [MUL_LAT-1:0][2*XLEN-1:0]  mprod_q, mprod_d;
  logic [MUL_LAT-1:0][1:0]         mop_q, mop_d;
  logic [MUL_LAT-1:0][ROB_W-1:0]   mrob_q, mrob_d;
  logic                            mul_stall;
  logic                            mul_fire;
  logic                            a_sgn, b_sgn;
  logic [2*XLEN-1:0]               a_ext, b_ext, prod;

  // One 2*XLEN multiply covers all four ops: extend each operand per its signedness,
  // the low 2*XLEN bits of the product are then correct in two's complement.
  assign a_sgn = (mul_op_i == 2'd1) || (mul_op_i == 2'd3);
  assign b_sgn = (mul_op_i == 2'd1);
  assign a_ext = {{XLEN{a_sgn & mul_src1_i[XLEN-1]}}, mul_src1_i};
  assign b_ext = {{XLEN{b_sgn & mul_src2_i[XLEN-1]}}, mul_src2_i};
  assign prod  = a_ext * b_ext;

  assign mul_stall   = mvld_q[LAST] && !mul_cmt_ready_i;
  assign mul_ready_o = !flush_i && !mul_stall;
  assign mul_fire    = mul_valid_i && mul_ready_o;

  // Pipeline advance: whole pipe shifts together unless the last stage is blocked
  always_comb begin
    mvld_d  = mvld_q;
    mprod_d = mprod_q;
    mop_d   = mop_q;
    mrob_d  = mrob_q;
    if (flush_i) begin
      mvld_d = '0;
    end else if (!mul_stall) begin
      mvld_d[0] = mul_fire;
      if (mul_fire) begin
        mprod_d[0] = prod;
        mop_d[0]   = mul_op_i;
        mrob_d[0]  = mul_rob_i;
      end
      for (int s = 1; s < MUL_LAT; s++) begin
        mvld_d[s]  = mvld_q[s-1];
        mprod_d[s] = mprod_q[s-1];
        mop_d[s]   = mop_q[s-1];
        mrob_d[s]  = mrob_q[s-1];
      end
    end
  end

  // Multiplier pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mvld_q  <= '0;
      mprod_q <= '0;
      mop_q   <= '0;
      mrob_q  <= '0;
    end else begin
      mvld_q  <= mvld_d;
      mprod_q <= mprod_d;
      mop_q   <= mop_d;
      mrob_q  <= mrob_d;
    end
  end

  // MUL takes the low half, every high variant takes the upper half
  assign mul_cmt_valid_o = mvld_q[LAST];
  assign mul_cmt_data_o  = (mop_q[LAST] == 2'd0) ? mprod_q[LAST][XLEN-1:0]
                                                 : mprod_q[LAST][2*XLEN-1:XLEN];
  assign mul_cmt_rob_o   = mrob_q[LAST];

endmodule

// File: tb/tb_int_exe_cluster.sv
// Testbench for int_exe_cluster: directed corner cases followed by randomized traffic.
// Expected results come from an arithmetic reference and a countdown model of each lane.
// Inputs change on the falling edge; outputs are checked just after it.
module tb_int_exe_cluster;
  localparam int N_ALU   = 2;
  localparam int XLEN    = 32;
  localparam int ROB_W   = 6;
  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, flush_i;
  logic [N_ALU-1:0]       alu_valid_i, alu_ready_o, alu_cmt_valid_o, alu_cmt_ready_i;
  logic [4*N_ALU-1:0]     alu_op_i;
  logic [XLEN*N_ALU-1:0]  alu_src1_i, alu_src2_i, alu_cmt_data_o;
  logic [ROB_W*N_ALU-1:0] alu_rob_i, alu_cmt_rob_o;
  logic                   mul_valid_i, mul_ready_o, mul_cmt_valid_o, mul_cmt_ready_i;
  logic [1:0]             mul_op_i;
  logic [XLEN-1:0]        mul_src1_i, mul_src2_i, mul_cmt_data_o;
  logic [ROB_W-1:0]       mul_rob_i, mul_cmt_rob_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] dat;
    logic [5:0]  rob;
    int          rem;
  } ent_t;

  ent_t alu_q[N_ALU][$];
  ent_t mul_q[$];

  int_exe_cluster #(.N_ALU(N_ALU), .XLEN(XLEN), .ROB_W(ROB_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_op_i(alu_op_i),
    .alu_src1_i(alu_src1_i), .alu_src2_i(alu_src2_i), .alu_rob_i(alu_rob_i),
    .alu_cmt_valid_o(alu_cmt_valid_o), .alu_cmt_ready_i(alu_cmt_ready_i),
    .alu_cmt_data_o(alu_cmt_data_o), .alu_cmt_rob_o(alu_cmt_rob_o),
    .mul_valid_i(mul_valid_i), .mul_ready_o(mul_ready_o), .mul_op_i(mul_op_i),
    .mul_src1_i(mul_src1_i), .mul_src2_i(mul_src2_i), .mul_rob_i(mul_rob_i),
    .mul_cmt_valid_o(mul_cmt_valid_o), .mul_cmt_ready_i(mul_cmt_ready_i),
    .mul_cmt_data_o(mul_cmt_data_o), .mul_cmt_rob_o(mul_cmt_rob_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      0:       return a + b;
      1:       return a - b;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      5:       return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6:       return (a < b) ? 32'd1 : 32'd0;
      7:       return a << sh;
      8:       return a >> sh;
      9:       return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      10:      return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = longint'($unsigned(a));
    ub = longint'($unsigned(b));
    case (op)
      0:       p = ua * ub;
      1:       p = sa * sb;
      2:       p = ua * ub;
      default: p = sa * ub;
    endcase
    return (op == 0) ? p[31:0] : p[63:32];
  endfunction

  // Checks the current outputs against the model, advances the model across the next edge.
  task automatic tick();
    ent_t e;
    logic vexp, rexp, mvis, mstall;
    #1;
    for (int i = 0; i < N_ALU; i++) begin
      vexp = (alu_q[i].size() != 0);
      rexp = !flush_i && (!vexp || alu_cmt_ready_i[i]);
      check("alu_cmt_valid", 64'(alu_cmt_valid_o[i]), 64'(vexp));
      check("alu_ready", 64'(alu_ready_o[i]), 64'(rexp));
      if (vexp) begin
        check("alu_data", 64'(alu_cmt_data_o[i*XLEN +: XLEN]), 64'(alu_q[i][0].dat));
        check("alu_rob", 64'(alu_cmt_rob_o[i*ROB_W +: ROB_W]), 64'(alu_q[i][0].rob));
      end
      if (rst || flush_i) begin
        alu_q[i].delete();
      end else begin
        if (vexp && alu_cmt_ready_i[i]) void'(alu_q[i].pop_front());
        if (alu_valid_i[i] && rexp) begin
          e.dat = ref_alu(int'(alu_op_i[i*4 +: 4]), alu_src1_i[i*XLEN +: XLEN],
                          alu_src2_i[i*XLEN +: XLEN]);
          e.rob = alu_rob_i[i*ROB_W +: ROB_W];
          e.rem = 0;
          alu_q[i].push_back(e);
        end
      end
    end
    mvis   = (mul_q.size() != 0) && (mul_q[0].rem == 0);
    mstall = mvis && !mul_cmt_ready_i;
    check("mul_cmt_valid", 64'(mul_cmt_valid_o), 64'(mvis));
    check("mul_ready", 64'(mul_ready_o), 64'(!flush_i && !mstall));
    if (mvis) begin
      check("mul_data", 64'(mul_cmt_data_o), 64'(mul_q[0].dat));
      check("mul_rob", 64'(mul_cmt_rob_o), 64'(mul_q[0].rob));
    end
    if (rst || flush_i) begin
      mul_q.delete();
    end else if (!mstall) begin
      if (mvis) void'(mul_q.pop_front());
      foreach (mul_q[k]) mul_q[k].rem--;
      if (mul_valid_i) begin
        e.dat = ref_mul(int'(mul_op_i), mul_src1_i, mul_src2_i);
        e.rob = mul_rob_i;
        e.rem = MUL_LAT - 1;
        mul_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_alu(input int lane, input int op, input logic [31:0] a,
                         input logic [31:0] b, input int rob);
    alu_valid_i[lane]           = 1'b1;
    alu_op_i[lane*4 +: 4]       = 4'(op);
    alu_src1_i[lane*XLEN +: XLEN] = a;
    alu_src2_i[lane*XLEN +: XLEN] = b;
    alu_rob_i[lane*ROB_W +: ROB_W] = 6'(rob);
  endtask

  task automatic set_mul(input int op, input logic [31:0] a, input logic [31:0] b, input int rob);
    mul_valid_i = 1'b1;
    mul_op_i    = 2'(op);
    mul_src1_i  = a;
    mul_src2_i  = b;
    mul_rob_i   = 6'(rob);
  endtask

  task automatic idle();
    alu_valid_i = '0;
    mul_valid_i = 1'b0;
  endtask

  // Issues one multiply and checks it appears exactly MUL_LAT cycles later
  task automatic mul_directed(input int op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] expv, input int rob);
    set_mul(op, a, b, rob);
    tick();
    idle();
    for (int c = 1; c <= MUL_LAT; c++) begin
      #1;
      check("mul_latency", 64'(mul_cmt_valid_o), 64'(c == MUL_LAT));
      if (c == MUL_LAT) begin
        check("mul_result", 64'(mul_cmt_data_o), 64'(expv));
        check("mul_rob_echo", 64'(mul_cmt_rob_o), 64'(rob));
      end
      tick();
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; flush_i = 1'b0;
    alu_valid_i = '0; alu_op_i = '0; alu_src1_i = '0; alu_src2_i = '0; alu_rob_i = '0;
    alu_cmt_ready_i = '0;
    mul_valid_i = 1'b0; mul_op_i = '0; mul_src1_i = '0; mul_src2_i = '0; mul_rob_i = '0;
    mul_cmt_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_alu_valid", 64'(alu_cmt_valid_o), 64'(0));
    check("rst_alu_data", 64'(alu_cmt_data_o), 64'(0));
    check("rst_alu_rob", 64'(alu_cmt_rob_o), 64'(0));
    check("rst_alu_ready", 64'(alu_ready_o), 64'(2'b11));
    check("rst_mul_valid", 64'(mul_cmt_valid_o), 64'(0));
    check("rst_mul_data", 64'(mul_cmt_data_o), 64'(0));
    check("rst_mul_rob", 64'(mul_cmt_rob_o), 64'(0));
    check("rst_mul_ready", 64'(mul_ready_o), 64'(1));

    alu_cmt_ready_i = '1;
    mul_cmt_ready_i = 1'b1;

    // ADD wrap-around on lane 0
    set_alu(0, 0, 32'hFFFF_FFFF, 32'h1, 5);
    tick(); idle(); #1;
    check("add_wrap_valid", 64'(alu_cmt_valid_o[0]), 64'(1));
    check("add_wrap_data", 64'(alu_cmt_data_o[31:0]), 64'(0));
    check("add_wrap_rob", 64'(alu_cmt_rob_o[5:0]), 64'(5));

    // SRA uses only the low shift bits; SLT on lane 0 in parallel
    set_alu(1, 9, 32'h8000_0000, 32'h24, 7);
    set_alu(0, 5, 32'hFFFF_FFFF, 32'h1, 8);
    tick(); idle(); #1;
    check("sra_data", 64'(alu_cmt_data_o[63:32]), 64'(32'hF800_0000));
    check("slt_data", 64'(alu_cmt_data_o[31:0]), 64'(1));
    set_alu(0, 6, 32'hFFFF_FFFF, 32'h1, 9);
    tick(); idle(); #1;
    check("sltu_data", 64'(alu_cmt_data_o[31:0]), 64'(0));
    tick();

    // Eight back-to-back ADDs, one result per cycle in order
    for (int k = 0; k <= 8; k++) begin
      idle();
      if (k < 8) set_alu(0, 0, 32'(k * 3), 32'd100, k);
      #1;
      if (k > 0) begin
        check("b2b_valid", 64'(alu_cmt_valid_o[0]), 64'(1));
        check("b2b_data", 64'(alu_cmt_data_o[31:0]), 64'((k - 1) * 3 + 100));
      end
      tick();
    end

    // Hold a result for three cycles, then drain
    alu_cmt_ready_i[0] = 1'b0;
    set_alu(0, 0, 32'd7, 32'd8, 9);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_alu(0, 0, 32'd1, 32'd1, 1);
      #1;
      check("hold_ready", 64'(alu_ready_o[0]), 64'(0));
      check("hold_data", 64'(alu_cmt_data_o[31:0]), 64'(15));
      check("hold_rob", 64'(alu_cmt_rob_o[5:0]), 64'(9));
      tick();
    end
    idle();
    alu_cmt_ready_i[0] = 1'b1;
    #1;
    check("drain_valid_before", 64'(alu_cmt_valid_o[0]), 64'(1));
    tick(); #1;
    check("drain_valid_after", 64'(alu_cmt_valid_o[0]), 64'(0));

    // Multiplier high-half corner cases
    mul_directed(1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3);
    mul_directed(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
    mul_directed(3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 5);

    // Flush with three multiplies in flight
    for (int k = 0; k < 3; k++) begin
      set_mul(0, 32'(k + 2), 32'd3, 20 + k);
      tick();
    end
    idle();
    flush_i = 1'b1;
    set_alu(0, 0, 32'd1, 32'd2, 1);
    #1;
    check("flush_mul_ready", 64'(mul_ready_o), 64'(0));
    check("flush_alu_ready", 64'(alu_ready_o[0]), 64'(0));
    tick();
    flush_i = 1'b0;
    idle();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("post_flush_mul_valid", 64'(mul_cmt_valid_o), 64'(0));
      check("post_flush_alu_valid", 64'(alu_cmt_valid_o[0]), 64'(0));
      tick();
    end
    mul_directed(0, 32'd6, 32'd7, 32'd42, 11);

    // Randomized traffic on all lanes with backpressure, flushes and occasional reset
    repeat (3000) begin
      for (int i = 0; i < N_ALU; i++) begin
        alu_valid_i[i]     = ($urandom_range(0, 3) != 0);
        alu_cmt_ready_i[i] = ($urandom_range(0, 3) != 0);
        set_alu(i, int'($urandom_range(0, 15)), rnd_val(), rnd_val(), int'($urandom_range(0, 63)));
        alu_valid_i[i]     = ($urandom_range(0, 3) != 0);
      end
      set_mul(int'($urandom_range(0, 3)), rnd_val(), rnd_val(), int'($urandom_range(0, 63)));
      mul_valid_i     = ($urandom_range(0, 2) != 0);
      mul_cmt_ready_i = ($urandom_range(0, 3) != 0);
      flush_i         = ($urandom_range(0, 39) == 0);
      rst             = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    flush_i = 1'b0;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
